fir_input_feeder: RTL and testbench



---
 rtl/fir_input_feeder.sv | 185 ++++++++++++++++++
 tb/tb_fir_input_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_input_feeder.sv
// fir_input_feeder
//
// Upstream stage of the parallel FIR top. Absorbs bursty samples over a
// valid/ready handshake into a FIFO and replays them as a gap-free stream
// of one sample per clock. Each output sample is tagged with its lane index
// (modulo CPS). When the FIFO runs dry the stream keeps going with zero
// samples flagged as underflow, so the lane phase never slips.
//
// Ports:
//   clk            data-rate clock of the filter top
//   rst            synchronous, active-high reset
//   s_data         input sample
//   s_valid        s_data is valid
//   s_ready        FIFO can accept a word this cycle (from registered level)
//   out_data       output sample, registered
//   out_valid      out_data belongs to the continuous stream
//   lane_idx       lane of out_data, 0..CPS-1
//   underflow      out_data is a zero-fill sample
//   underflow_cnt  saturating count of zero-fill samples
//   level          FIFO occupancy, registered
//
// State table:
//   state   | meaning
//   IDLE    | waiting for the first prefill after reset, no output yet
//   RUN     | popping one word per cycle
//   STARVED | FIFO ran dry, emitting zeros until refilled to PREFILL

module fir_input_feeder #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8,
  parameter int CPS     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [5:0]               lane_idx,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [5:0]    LANE_MAX  = 6'(CPS - 1);
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic push;
  logic pop;
  logic fill;

  // s_ready looks only at the registered level, so a full FIFO refuses a
  // word even in a cycle that also pops.
  assign s_ready = (level < DEPTH_L);
  assign push    = s_valid && s_ready;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (level >= PREFILL_L) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (level != '0) begin
          pop = 1'b1;
        end else begin
          fill      = 1'b1;
          state_nxt = STARVED;
        end
      end
      STARVED: begin
        // The refill cycle already acts as the first RUN cycle: it pops
        // instead of emitting another zero, so the stream has no gap.
        if (level >= PREFILL_L) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end else begin
          fill = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FIFO storage and pointers (DEPTH is a power of two, so the pointers
  // wrap on their own)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output stream
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      lane_idx      <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (pop) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
        underflow <= 1'b0;
      end else if (fill) begin
        out_data  <= '0;
        out_valid <= 1'b1;
        underflow <= 1'b1;
        if (underflow_cnt != CNT_MAX) begin
          underflow_cnt <= underflow_cnt + 16'd1;
        end
      end
      // The first sample keeps lane 0; every later one steps the lane.
      if ((pop || fill) && out_valid) begin
        if (lane_idx == LANE_MAX) begin
          lane_idx <= '0;
        end else begin
          lane_idx <= lane_idx + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_input_feeder.sv
// Testbench for fir_input_feeder. Expected samples are queued by the
// stimulus; negedge monitors pop and compare whenever out_valid is high.

module tb_fir_input_feeder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic [5:0]  lane_idx;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic [4:0]  level;

  // second instance with PREFILL = DEPTH = 16 for backpressure
  logic        rst_f;
  logic [15:0] s_data_f;
  logic        s_valid_f;
  logic        s_ready_f;
  logic [15:0] out_data_f;
  logic        out_valid_f;
  logic [5:0]  lane_idx_f;
  logic        underflow_f;
  logic [15:0] underflow_cnt_f;
  logic [4:0]  level_f;

  fir_input_feeder u_dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .lane_idx      (lane_idx),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt),
    .level         (level)
  );

  fir_input_feeder #(.DEPTH(16), .PREFILL(16)) u_full (
    .clk           (clk),
    .rst           (rst_f),
    .s_data        (s_data_f),
    .s_valid       (s_valid_f),
    .s_ready       (s_ready_f),
    .out_data      (out_data_f),
    .out_valid     (out_valid_f),
    .lane_idx      (lane_idx_f),
    .underflow     (underflow_f),
    .underflow_cnt (underflow_cnt_f),
    .level         (level_f)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  lane;
    logic        uf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp_f[$];
  logic [5:0] exp_lane;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       full_done = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void exp_push(input logic [15:0] d, input logic uf);
    exp_t e;
    e.data = d;
    e.lane = exp_lane;
    e.uf   = uf;
    exp_q.push_back(e);
    exp_lane = (exp_lane == 6'd3) ? 6'd0 : exp_lane + 6'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_data"},  32'(out_data), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_lane_idx"},  32'(lane_idx), 32'h0);
    chk({tag, "_underflow"}, 32'(underflow), 32'h0);
    chk({tag, "_uf_cnt"},    32'(underflow_cnt), 32'h0);
    chk({tag, "_level"},     32'(level), 32'h0);
    chk({tag, "_s_ready"},   32'(s_ready), 32'h1);
  endtask

  // monitors
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got data %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("lane_idx", 32'(lane_idx), 32'(e.lane));
        chk("underflow", 32'(underflow), 32'(e.uf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid_f === 1'b1) begin
      if (exp_f.size() == 0) begin
        n_checks++;
        $display("FAIL full_unexpected_output: got data %0h expected none", out_data_f);
      end else begin
        e = exp_f.pop_front();
        chk("full_out_data", 32'(out_data_f), 32'(e.data));
        chk("full_lane_idx", 32'(lane_idx_f), 32'(e.lane));
        chk("full_underflow", 32'(underflow_f), 32'(e.uf));
      end
    end
  end

  // backpressure on the PREFILL=DEPTH instance
  initial begin
    logic [15:0] next_w;
    logic        rdy;
    logic        rdy_tbl [4];
    exp_t        e;
    rdy_tbl[0] = 1'b1; rdy_tbl[1] = 1'b0; rdy_tbl[2] = 1'b0; rdy_tbl[3] = 1'b1;
    rst_f = 1'b1; s_valid_f = 1'b0; s_data_f = '0;
    tick(); tick();
    chk("full_reset_level", 32'(level_f), 32'h0);
    rst_f  = 1'b0;
    next_w = 16'd1;
    for (int n = 0; n < 24; n++) begin
      e.data = 16'(n + 1);
      e.lane = 6'(n % 4);
      e.uf   = 1'b0;
      exp_f.push_back(e);
    end
    for (int c = 0; c <= 40; c++) begin
      s_valid_f = 1'b1;
      s_data_f  = next_w;
      rdy       = s_ready_f;
      if (c >= 15 && c <= 18) chk("full_s_ready", 32'(s_ready_f), 32'(rdy_tbl[c-15]));
      if (c == 16) chk("full_level_16", 32'(level_f), 32'd16);
      tick();
      if (rdy) next_w = next_w + 16'd1;
    end
    chk("full_level_steady", 32'(level_f), 32'd15);
    rst_f = 1'b1; s_valid_f = 1'b0;
    tick();
    chk("full_queue_drained", 32'(exp_f.size()), 32'h0);
    full_done = 1'b1;
  end

  // main sequence
  initial begin
    localparam int N_SAT = 70030;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    chk_reset("rst0");

    // prefill start, starvation, refill
    rst = 1'b0;
    exp_lane = '0;
    for (int i = 1; i <= 8; i++) exp_push(16'(i), 1'b0);
    for (int i = 0; i < 21; i++) exp_push(16'h0, 1'b1);
    for (int i = 9; i <= 16; i++) exp_push(16'(i), 1'b0);
    for (int i = 0; i < 4; i++) exp_push(16'h0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      s_valid = (c < 8) || (c >= 30 && c < 38);
      s_data  = (c < 8) ? 16'(c + 1) : ((c >= 30 && c < 38) ? 16'(c - 21) : 16'h0);
      tick();
    end
    chk("starve_uf_cnt", 32'(underflow_cnt), 32'd25);
    chk("starve_out_valid", 32'(out_valid), 32'h1);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    chk_reset("rst1");
    chk("phaseA_queue_drained", 32'(exp_q.size()), 32'h0);

    // steady stream across pointer wraps, then reset mid-stream at level 5
    rst = 1'b0;
    exp_lane = '0;
    for (int n = 0; n <= 42; n++) exp_push(16'h100 + 16'(n), 1'b0);
    for (int c = 0; c < 52; c++) begin
      s_valid = (c < 8) || (c >= 9 && c <= 48);
      s_data  = 16'h100 + ((c < 8) ? 16'(c) : 16'(c - 1));
      tick();
      if (c >= 8 && c <= 48) chk("level_steady", 32'(level), 32'd8);
    end
    chk("level_before_rst", 32'(level), 32'd5);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    chk_reset("rst2");
    chk("phaseB_queue_drained", 32'(exp_q.size()), 32'h0);

    // restart after reset, then long starvation to saturate the counter
    rst = 1'b0;
    exp_lane = '0;
    for (int n = 0; n < 8; n++) exp_push(16'h200 + 16'(n), 1'b0);
    for (int i = 0; i < N_SAT - 17; i++) exp_push(16'h0, 1'b1);
    for (int c = 0; c < N_SAT; c++) begin
      s_valid = (c < 8);
      s_data  = (c < 8) ? 16'h200 + 16'(c) : 16'h0;
      tick();
      if (c == 65550) chk("uf_cnt_below_sat", 32'(underflow_cnt), 32'd65534);
      if (c == 65551) chk("uf_cnt_at_sat", 32'(underflow_cnt), 32'hFFFF);
    end
    chk("uf_cnt_held", 32'(underflow_cnt), 32'hFFFF);
    chk("sat_underflow", 32'(underflow), 32'h1);
    rst = 1'b1;
    tick();
    chk_reset("rst3");
    chk("phaseC_queue_drained", 32'(exp_q.size()), 32'h0);

    for (int i = 0; i < 100 && !full_done; i++) tick();
    if (!full_done) begin
      n_checks++;
      $display("FAIL full_timeout: got done=0 expected done=1");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
